// File: rtl/sc_fifo_pkg.sv
// Shared sizing helpers and parameter limits for the sc_fifo_fwft FIFO family.
package sc_fifo_pkg;

    localparam int MIN_DATA_WIDTH = 1;
    localparam int MIN_DEPTH      = 2;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sc_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module sc_fifo_ram
    import sc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = ptr_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    // No reset on the array so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sc_fifo_fwft.sv
// Single-clock show-ahead FIFO, arbitrary depth, with flush and status flags.
// Optional sticky overflow/underflow detection: define SC_FIFO_FWFT_ERR_EN.
module sc_fifo_fwft
    import sc_fifo_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter int   DEPTH      = 8,
    parameter int   AFULL_LVL  = DEPTH - 1,
    parameter int   AEMPTY_LVL = 1,
    localparam int  CNT_WIDTH  = cnt_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [CNT_WIDTH-1:0]  used_words_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int PTR_WIDTH = ptr_width(DEPTH);

    initial begin
        if (DATA_WIDTH < MIN_DATA_WIDTH) $error("sc_fifo_fwft: DATA_WIDTH must be >= 1");
        if (DEPTH < MIN_DEPTH) $error("sc_fifo_fwft: DEPTH must be >= 2");
        if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) $error("sc_fifo_fwft: AFULL_LVL out of range");
        if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) $error("sc_fifo_fwft: AEMPTY_LVL out of range");
    end

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] used_q, used_d;
    logic                 valid_q, valid_d;
    logic                 full_q, full_d;
    logic                 wr_req, rd_req, ram_nonempty, ram_wr_en, ram_rd_en;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_req       = wr_i & ~full_q;
    assign rd_req       = rd_i & valid_q;
    // RAM occupancy is the total count minus the word parked in the output register.
    assign ram_nonempty = used_q > CNT_WIDTH'(valid_q);
    assign ram_wr_en    = wr_req & ~flush_i;
    assign ram_rd_en    = ~flush_i & ram_nonempty & (~valid_q | rd_req);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        used_d   = used_q;
        valid_d  = valid_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            used_d   = '0;
            valid_d  = 1'b0;
        end else begin
            if (wr_req) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (ram_rd_en) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                valid_d  = 1'b1;
            end else if (rd_req) begin
                valid_d  = 1'b0;
            end
            case ({wr_req, rd_req})
                2'b10:   used_d = used_q + 1'b1;
                2'b01:   used_d = used_q - 1'b1;
                default: used_d = used_q;
            endcase
        end
        full_d = (used_d == CNT_WIDTH'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    sc_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data_i),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data_o)
    );

    assign used_words_o   = used_q;
    assign full_o         = full_q;
    assign empty_o        = ~valid_q;
    assign almost_full_o  = used_q >= CNT_WIDTH'(AFULL_LVL);
    assign almost_empty_o = used_q <= CNT_WIDTH'(AEMPTY_LVL);

`ifdef SC_FIFO_FWFT_ERR_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (flush_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            if (wr_i & full_q)   ovf_d = 1'b1;
            if (rd_i & ~valid_q) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_sc_fifo_fwft.sv
// Bench for sc_fifo_fwft: two instances (DEPTH=8 with AF=6/AE=2, DEPTH=5 defaults)
// share one stimulus stream and are checked every cycle against a queue model.
module tb_sc_fifo_fwft;

`ifdef SC_FIFO_FWFT_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    localparam int NI = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush_i = 1'b0;
    logic       wr_i = 1'b0;
    logic [7:0] wr_data_i = '0;
    logic       rd_i = 1'b0;

    logic [7:0] rdata0, rdata1;
    logic [3:0] used0;
    logic [2:0] used1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;

    int total = 0;
    int passed = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    sc_fifo_fwft #(.DATA_WIDTH(8), .DEPTH(8), .AFULL_LVL(6), .AEMPTY_LVL(2)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush_i), .wr_i(wr_i), .wr_data_i(wr_data_i),
        .rd_i(rd_i), .rd_data_o(rdata0), .used_words_o(used0), .full_o(full0), .empty_o(empty0),
        .almost_full_o(af0), .almost_empty_o(ae0), .overflow_o(ovf0), .underflow_o(udf0));

    sc_fifo_fwft #(.DATA_WIDTH(8), .DEPTH(5)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush_i), .wr_i(wr_i), .wr_data_i(wr_data_i),
        .rd_i(rd_i), .rd_data_o(rdata1), .used_words_o(used1), .full_o(full1), .empty_o(empty1),
        .almost_full_o(af1), .almost_empty_o(ae1), .overflow_o(ovf1), .underflow_o(udf1));

    function automatic int dep(input int k);
        return (k == 0) ? 8 : 5;
    endfunction
    function automatic int afl(input int k);
        return (k == 0) ? 6 : 4;
    endfunction
    function automatic int ael(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: list of held words, plus whether the head is presented on the output.
    logic [7:0] mq [NI][$];
    bit         mvis [NI];
    bit         movf [NI];
    bit         mudf [NI];

    always @(posedge clk or negedge rst_n) begin
        int  sz;
        bit  wa, ra;
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                mq[k].delete();
                mvis[k] = 1'b0; movf[k] = 1'b0; mudf[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                sz = mq[k].size();
                wa = wr_i && (sz < dep(k));
                ra = rd_i && mvis[k];
                if (flush_i) begin
                    mq[k].delete();
                    mvis[k] = 1'b0; movf[k] = 1'b0; mudf[k] = 1'b0;
                end else begin
                    if (ERR && wr_i && sz == dep(k)) movf[k] = 1'b1;
                    if (ERR && rd_i && !mvis[k])     mudf[k] = 1'b1;
                    // A presented word stays presented unless read; after a read the
                    // next word is presented only if one was already waiting behind it.
                    mvis[k] = ra ? (sz > 1) : (mvis[k] || sz > 0);
                    if (ra) void'(mq[k].pop_front());
                    if (wa) mq[k].push_back(wr_data_i);
                end
            end
        end
    end

    always @(negedge clk) begin
        int u [NI];
        int d [NI];
        int f [NI], e [NI], a [NI], b [NI], o [NI], n [NI];
        int sz;
        if (cmp_en) begin
            u[0] = int'(used0); d[0] = int'(rdata0); f[0] = int'(full0); e[0] = int'(empty0);
            a[0] = int'(af0);   b[0] = int'(ae0);    o[0] = int'(ovf0);  n[0] = int'(udf0);
            u[1] = int'(used1); d[1] = int'(rdata1); f[1] = int'(full1); e[1] = int'(empty1);
            a[1] = int'(af1);   b[1] = int'(ae1);    o[1] = int'(ovf1);  n[1] = int'(udf1);
            for (int k = 0; k < NI; k++) begin
                sz = mq[k].size();
                check($sformatf("dut%0d used", k),  u[k], sz);
                check($sformatf("dut%0d full", k),  f[k], int'(sz == dep(k)));
                check($sformatf("dut%0d empty", k), e[k], int'(!mvis[k]));
                check($sformatf("dut%0d afull", k), a[k], int'(sz >= afl(k)));
                check($sformatf("dut%0d aempty", k), b[k], int'(sz <= ael(k)));
                check($sformatf("dut%0d ovf", k),   o[k], int'(movf[k]));
                check($sformatf("dut%0d udf", k),   n[k], int'(mudf[k]));
                if (mvis[k] && sz > 0) check($sformatf("dut%0d rdata", k), d[k], int'(mq[k][0]));
            end
        end
    end

    // Inputs are applied now, sampled at the next rising edge; returns 1 time unit after it.
    task automatic step(input bit w, input logic [7:0] dat, input bit r, input bit f);
        wr_i = w; wr_data_i = dat; rd_i = r; flush_i = f;
        @(posedge clk);
        #1;
        wr_i = 1'b0; rd_i = 1'b0; flush_i = 1'b0;
    endtask

    logic [7:0]  got [$];
    int          sent;
    bit          wfull;
    int unsigned pw, pr;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset used", int'(used0), 0);
        check("reset empty", int'(empty0), 1);
        check("reset full", int'(full0), 0);
        check("reset aempty", int'(ae0), 1);
        check("reset afull", int'(af0), 0);
        check("reset rdata", int'(rdata0), 0);
        check("reset ovf", int'(ovf0), 0);
        check("reset udf", int'(udf0), 0);
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fall-through: write sampled at edge E1, word presented after E2.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("lat used after E1", int'(used0), 1);
        check("lat empty after E1", int'(empty0), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("lat empty after E2", int'(empty0), 0);
        check("lat rdata after E2", int'(rdata0), 8'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("lat empty after read", int'(empty0), 1);
        check("lat used after read", int'(used0), 0);

        // Fill DEPTH=8 instance, overflow attempt, read+write at full, drain.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            check("fill used", int'(used0), i);
            check("fill afull", int'(af0), int'(i >= 6));
        end
        check("fill full", int'(full0), 1);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf used", int'(used0), 8);
        check("ovf head", int'(rdata0), 8'h01);
        check("ovf flag", int'(ovf0), int'(ERR));
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("rw at full used", int'(used0), 7);
        check("rw at full full", int'(full0), 0);
        check("rw at full head", int'(rdata0), 8'h02);
        for (int i = 2; i <= 8; i++) begin
            check("drain order", int'(rdata0), i);
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("drain used", int'(used0), 8 - i);
            check("drain aempty", int'(ae0), int'(8 - i <= 2));
        end
        check("drained empty", int'(empty0), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("udf flag", int'(udf0), int'(ERR));

        // Flush at 4 words with a concurrent write.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        check("pre-flush used", int'(used0), 4);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        check("flush used", int'(used0), 0);
        check("flush empty", int'(empty0), 1);
        check("flush ovf", int'(ovf0), 0);
        check("flush udf", int'(udf0), 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("flush write dropped", int'(used0), 0);
        check("flush stays empty", int'(empty0), 1);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        wr_i = 1'b1; wr_data_i = 8'h14; rst_n = 1'b0;
        #1;
        check("async rst used", int'(used0), 0);
        check("async rst empty", int'(empty0), 1);
        check("async rst rdata", int'(rdata0), 0);
        check("async rst full", int'(full1), 0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1; wr_i = 1'b0;

        // Streaming through DEPTH=5: 20 words, pointers wrap several times.
        sent = 0;
        for (int c = 0; c < 200 && got.size() < 20; c++) begin
            if (!empty1) got.push_back(rdata1);
            wfull = full1;
            step(sent < 20, 8'(sent), 1'b1, 1'b0);
            if (sent < 20 && !wfull) sent++;
        end
        check("stream count", got.size(), 20);
        for (int i = 0; i < got.size(); i++) check("stream order", int'(got[i]), i);

        // Randomized traffic with varying read/write pressure.
        for (int seg = 0; seg < 20; seg++) begin
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int c = 0; c < 150; c++) begin
                step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                     $urandom_range(0, 99) == 0);
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
